btn_event_gen: RTL and testbench

- Front-end stage that drives the dual-counter block's En/Slt inputs.
- Takes two raw, asynchronous push-button lines.
- Synchronises and debounces each line, then detects press (rising) events.
- Arbitrates round-robin between channels and issues at most one single-cycle En pulse per cycle, with Slt naming the channel.

---
 rtl/btn_pkg.sv | 12 +
 rtl/btn_debounce.sv | 54 +++++
 rtl/btn_event_gen.sv | 92 +++++++++
 tb/tb_btn_event_gen.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button event front end.
// Channel encoding here matches the Slt output of btn_event_gen.
package btn_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

    typedef logic ch_t;

    localparam ch_t CH0 = 1'b0;
    localparam ch_t CH1 = 1'b1;

endpackage

// File: rtl/btn_debounce.sv
// One button channel: two-flop synchroniser, stability counter, debounced
// level and a rise pulse that fires on the same edge the level goes high.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic Clk,
    input  logic Reset,
    input  logic raw,
    output logic deb,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        cnt_d   = cnt_q;
        if (sync2_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            deb_d = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Rise looks at deb_d so the pending flag can be set on the flip edge.
    assign rise = ~Reset & deb_d & ~deb_q;
    assign deb  = deb_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/btn_event_gen.sv
// Two debounced push-button channels feeding a round-robin arbiter that
// emits at most one registered En pulse per cycle, Slt naming the channel.
module btn_event_gen
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Btn0,
    input  logic Btn1,
    output logic En,
    output logic Slt
);

    logic [1:0] rise;
    logic [1:0] deb_unused;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb0 (
        .Clk   (Clk),
        .Reset (Reset),
        .raw   (Btn0),
        .deb   (deb_unused[0]),
        .rise  (rise[0])
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb1 (
        .Clk   (Clk),
        .Reset (Reset),
        .raw   (Btn1),
        .deb   (deb_unused[1]),
        .rise  (rise[1])
    );

    logic [1:0] pend_q, pend_d;
    ch_t        last_q, last_d;
    logic       en_q, en_d;
    ch_t        slt_q, slt_d;
    logic       grant_v;
    ch_t        grant_ch;

    always_comb begin
        grant_v  = 1'b0;
        grant_ch = CH0;
        case (pend_q)
            2'b01: begin
                grant_v  = 1'b1;
                grant_ch = CH0;
            end
            2'b10: begin
                grant_v  = 1'b1;
                grant_ch = CH1;
            end
            2'b11: begin
                grant_v  = 1'b1;
                grant_ch = ~last_q;
            end
            default: begin
                grant_v  = 1'b0;
                grant_ch = CH0;
            end
        endcase

        en_d   = grant_v;
        slt_d  = grant_v ? grant_ch : CH0;
        last_d = grant_v ? grant_ch : last_q;
        pend_d = pend_q;
        if (grant_v) begin
            pend_d[grant_ch] = 1'b0;
        end
        // A new rise on the granted channel keeps it pending.
        pend_d = pend_d | rise;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pend_q <= 2'b00;
            last_q <= CH1;
            en_q   <= 1'b0;
            slt_q  <= CH0;
        end else begin
            pend_q <= pend_d;
            last_q <= last_d;
            en_q   <= en_d;
            slt_q  <= slt_d;
        end
    end

    assign En  = en_q;
    assign Slt = slt_q;

endmodule

// File: tb/tb_btn_event_gen.sv
// Scoreboard bench: instance 0 uses DEBOUNCE_CYCLES=4, instance 1 uses 1.
// A window-based reference model predicts every En/Slt pulse and its cycle.
module tb_btn_event_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst [2];
    logic btn [2][2];
    logic en  [2];
    logic slt [2];

    btn_event_gen #(.DEBOUNCE_CYCLES(4)) dut0 (
        .Clk   (clk),
        .Reset (rst[0]),
        .Btn0  (btn[0][0]),
        .Btn1  (btn[0][1]),
        .En    (en[0]),
        .Slt   (slt[0])
    );

    btn_event_gen #(.DEBOUNCE_CYCLES(1)) dut1 (
        .Clk   (clk),
        .Reset (rst[1]),
        .Btn0  (btn[1][0]),
        .Btn1  (btn[1][1]),
        .En    (en[1]),
        .Slt   (slt[1])
    );

    typedef struct {
        int   cyc;
        logic ch;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int pc    [2][2];
    int base  [2][2];
    int lastp [2][2];

    logic         ms1  [2][2];
    logic         ms2  [2][2];
    logic         mdeb [2][2];
    logic [255:0] mhist[2][2];
    logic [1:0]   mpend[2];
    logic         mlast[2];

    function automatic int dcof(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    task automatic qpush(input int i, input exp_t e);
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic qfront(input int i, output exp_t e);
        if (i == 0) e = q0[0];
        else        e = q1[0];
    endtask

    task automatic qpop(input int i);
        if (i == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endtask

    // Debounced level flips once the last DEBOUNCE_CYCLES synchronised
    // samples all disagree with it; pending grants follow round-robin.
    task automatic model_step(input int i);
        logic [255:0] mask;
        logic [255:0] win;
        logic         rose [2];
        int           g;
        exp_t         e;
        mask = (256'd1 << dcof(i)) - 256'd1;
        if (rst[i]) begin
            for (int c = 0; c < 2; c++) begin
                ms1[i][c]   = 1'b0;
                ms2[i][c]   = 1'b0;
                mdeb[i][c]  = 1'b0;
                mhist[i][c] = '0;
            end
            mpend[i] = 2'b00;
            mlast[i] = 1'b1;
            return;
        end
        g = -1;
        if (mpend[i] == 2'b11) g = mlast[i] ? 0 : 1;
        else if (mpend[i][0]) g = 0;
        else if (mpend[i][1]) g = 1;
        for (int c = 0; c < 2; c++) begin
            rose[c] = 1'b0;
            mhist[i][c] = {mhist[i][c][254:0], ms2[i][c]};
            ms2[i][c] = ms1[i][c];
            ms1[i][c] = btn[i][c];
            win = mhist[i][c] & mask;
            if (!mdeb[i][c] && win == mask) begin
                mdeb[i][c] = 1'b1;
                rose[c] = 1'b1;
            end else if (mdeb[i][c] && win == '0) begin
                mdeb[i][c] = 1'b0;
            end
        end
        if (g >= 0) begin
            mpend[i][g] = 1'b0;
            mlast[i] = (g == 1);
            e.cyc = cyc;
            e.ch = (g == 1);
            qpush(i, e);
        end
        for (int c = 0; c < 2; c++)
            if (rose[c]) mpend[i][c] = 1'b1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_step(0);
            model_step(1);
        end
    end

    task automatic mon(input int i);
        exp_t e;
        int   n;
        n = qsize(i);
        if (n > 0) qfront(i, e);
        if (en[i] === 1'b1) begin
            checks++;
            pc[i][slt[i] ? 1 : 0]++;
            lastp[i][slt[i] ? 1 : 0] = cyc;
            if (n == 0) begin
                failures++;
                $display("FAIL unexpected_pulse inst=%0d cyc=%0d got En=1 Slt=%0b want En=0",
                         i, cyc, slt[i]);
            end else begin
                qpop(i);
                if (e.cyc != cyc || e.ch !== slt[i]) begin
                    failures++;
                    $display("FAIL pulse inst=%0d got cyc=%0d Slt=%0b want cyc=%0d Slt=%0b",
                             i, cyc, slt[i], e.cyc, e.ch);
                end
            end
        end else begin
            checks++;
            if (en[i] !== 1'b0 || slt[i] !== 1'b0) begin
                failures++;
                $display("FAIL idle_out inst=%0d cyc=%0d got En=%b Slt=%b want 0 0",
                         i, cyc, en[i], slt[i]);
            end
            if (n > 0 && e.cyc <= cyc) begin
                checks++;
                failures++;
                $display("FAIL missing_pulse inst=%0d got none want cyc=%0d Slt=%0b",
                         i, e.cyc, e.ch);
                qpop(i);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            mon(0);
            mon(1);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        for (int i = 0; i < 2; i++)
            for (int c = 0; c < 2; c++)
                base[i][c] = pc[i][c];
    endtask

    task automatic expect_pulses(input string name, input int i,
                                 input int w0, input int w1);
        int g0, g1;
        g0 = pc[i][0] - base[i][0];
        g1 = pc[i][1] - base[i][1];
        checks++;
        if (g0 != w0 || g1 != w1) begin
            failures++;
            $display("FAIL %s got ch0=%0d ch1=%0d want ch0=%0d ch1=%0d",
                     name, g0, g1, w0, w1);
        end
    endtask

    task automatic expect_at(input string name, input int i, input int c,
                             input int want);
        checks++;
        if (lastp[i][c] != want) begin
            failures++;
            $display("FAIL %s got cyc=%0d want cyc=%0d", name, lastp[i][c], want);
        end
    endtask

    int k;

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1;
            for (int c = 0; c < 2; c++) begin
                btn[i][c] = 1'b0;
                pc[i][c] = 0;
                lastp[i][c] = -1;
            end
        end
        tick(3);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        tick(4);

        snap();
        k = cyc + 1;
        btn[0][0] = 1'b1;
        tick(20);
        btn[0][0] = 1'b0;
        tick(14);
        expect_pulses("clean_press", 0, 1, 0);
        expect_at("clean_latency", 0, 0, k + 6);

        snap();
        btn[0][1] = 1'b1; tick(3);
        btn[0][1] = 1'b0; tick(1);
        btn[0][1] = 1'b1; tick(3);
        btn[0][1] = 1'b0; tick(14);
        expect_pulses("bounce_reject", 0, 0, 0);
        snap();
        btn[0][1] = 1'b1; tick(6);
        btn[0][1] = 1'b0; tick(14);
        expect_pulses("bounce_then_hold", 0, 0, 1);

        rst[0] = 1'b1; tick(2);
        rst[0] = 1'b0;
        snap();
        k = cyc + 1;
        btn[0][0] = 1'b1;
        btn[0][1] = 1'b1;
        tick(14);
        expect_at("tie_first_ch0", 0, 0, k + 6);
        expect_at("tie_second_ch1", 0, 1, k + 7);
        btn[0][0] = 1'b0;
        btn[0][1] = 1'b0;
        tick(8);
        k = cyc + 1;
        btn[0][0] = 1'b1;
        btn[0][1] = 1'b1;
        tick(14);
        expect_at("retie_first_ch0", 0, 0, k + 6);
        expect_at("retie_second_ch1", 0, 1, k + 7);
        btn[0][0] = 1'b0;
        btn[0][1] = 1'b0;
        tick(14);
        expect_pulses("tie_counts", 0, 2, 2);

        snap();
        k = cyc + 1;
        btn[0][0] = 1'b1;
        tick(4);
        rst[0] = 1'b1;
        tick(1);
        rst[0] = 1'b0;
        tick(16);
        btn[0][0] = 1'b0;
        tick(14);
        expect_pulses("reset_mid", 0, 1, 0);
        expect_at("reset_mid_latency", 0, 0, k + 11);

        for (int t = 0; t < 600; t++) begin
            for (int c = 0; c < 2; c++)
                if ($urandom_range(0, 5) == 0) btn[0][c] = ~btn[0][c];
            rst[0] = ($urandom_range(0, 199) == 0);
            tick(1);
        end
        rst[0] = 1'b0;
        btn[0][0] = 1'b0;
        btn[0][1] = 1'b0;
        tick(20);

        snap();
        for (int t = 0; t < 400; t++) begin
            btn[1][0] = ((t % 4) < 2);
            btn[1][1] = (((t + 3) % 4) < 2);
            tick(1);
        end
        btn[1][0] = 1'b0;
        btn[1][1] = 1'b0;
        tick(10);
        expect_pulses("dc1_stress", 1, 100, 100);

        for (int t = 0; t < 300; t++) begin
            for (int c = 0; c < 2; c++)
                if ($urandom_range(0, 2) == 0) btn[1][c] = ~btn[1][c];
            rst[1] = ($urandom_range(0, 99) == 0);
            tick(1);
        end
        rst[1] = 1'b0;
        btn[1][0] = 1'b0;
        btn[1][1] = 1'b0;
        tick(10);

        for (int i = 0; i < 2; i++) begin
            checks++;
            if (qsize(i) != 0) begin
                failures++;
                $display("FAIL drain inst=%0d got %0d outstanding want 0",
                         i, qsize(i));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
